// File: rtl/fcvrt_uw.sv
// rtl/fcvrt_uw.sv - multi-cycle unsigned 32-bit integer to binary32 converter
module fcvrt_uw (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] num1,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_num,
    output logic        out_nx
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    logic [1:0]  state;
    logic [31:0] norm;
    logic [2:0]  rm_q;
    logic [4:0]  s;

    logic [7:0]  rnd_exp;
    logic [22:0] rnd_man;
    logic        rnd_g;
    logic        rnd_st;
    logic        rnd_inc;
    logic [30:0] rnd_sum;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Exponent is biased 127 + (31 - s); the add lets a mantissa carry bump the exponent.
    always_comb begin
        rnd_exp = 8'd158 - {3'b000, s};
        rnd_man = norm[30:8];
        rnd_g   = norm[7];
        rnd_st  = |norm[6:0];
        rnd_inc = 1'b0;
        case (rm_q)
            RM_RTZ, RM_RDN: rnd_inc = 1'b0;
            RM_RUP:         rnd_inc = rnd_g | rnd_st;
            RM_RMM:         rnd_inc = rnd_g;
            default:        rnd_inc = rnd_g & (rnd_st | rnd_man[0]);
        endcase
        rnd_sum = {rnd_exp, rnd_man} + {30'd0, rnd_inc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            norm    <= 32'd0;
            rm_q    <= RM_RNE;
            s       <= 5'd0;
            out_num <= 32'd0;
            out_nx  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        norm  <= num1;
                        rm_q  <= rm;
                        s     <= 5'd0;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (norm[31] || (norm == 32'd0)) begin
                        state <= ROUND;
                    end else begin
                        norm <= {norm[30:0], 1'b0};
                        s    <= s + 5'd1;
                    end
                end
                ROUND: begin
                    if (norm == 32'd0) begin
                        out_num <= 32'd0;
                        out_nx  <= 1'b0;
                    end else begin
                        out_num <= {1'b0, rnd_sum};
                        out_nx  <= rnd_g | rnd_st;
                    end
                    state <= DONE;
                end
                default: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fcvrt_uw.sv
// tb/tb_fcvrt_uw.sv - directed self-checking bench for fcvrt_uw
module tb_fcvrt_uw;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] num1;
    logic [2:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_num;
    logic        out_nx;

    int n_checks;
    int n_pass;

    fcvrt_uw dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num1      (num1),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .out_nx    (out_nx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one operand, scramble inputs during the operation, then check latency and result.
    task automatic run(input string tag, input logic [31:0] op, input logic [2:0] mode,
                       input logic [31:0] exp_num, input logic exp_nx, input int exp_lat,
                       input int hold);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        num1     = op;
        rm       = mode;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        num1     = $urandom;
        rm       = 3'($urandom_range(0, 7));
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            num1 = $urandom;
            if (out_valid) break;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_num"}, out_num, exp_num);
        chk({tag, "_nx"}, {31'd0, out_nx}, {31'd0, exp_nx});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_num"}, out_num, exp_num);
            chk({tag, "_hold_nx"}, {31'd0, out_nx}, {31'd0, exp_nx});
            chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        num1      = 32'h0000_00FF;
        rm        = 3'b000;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_num", out_num, 32'd0);
        chk("rst_out_nx", {31'd0, out_nx}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;

        run("one_rne",   32'h0000_0001, 3'b000, 32'h3F80_0000, 1'b0, 33, 0);
        run("msb",       32'h8000_0000, 3'b000, 32'h4F00_0000, 1'b0, 2, 0);
        run("zero",      32'h0000_0000, 3'b000, 32'h0000_0000, 1'b0, 2, 0);
        run("tie_rne",   32'h0100_0001, 3'b000, 32'h4B80_0000, 1'b1, 9, 0);
        run("tie_rtz",   32'h0100_0001, 3'b001, 32'h4B80_0000, 1'b1, 9, 0);
        run("tie_rdn",   32'h0100_0001, 3'b010, 32'h4B80_0000, 1'b1, 9, 0);
        run("tie_rup",   32'h0100_0001, 3'b011, 32'h4B80_0001, 1'b1, 9, 0);
        run("tie_rmm",   32'h0100_0001, 3'b100, 32'h4B80_0001, 1'b1, 9, 0);
        run("max_rne",   32'hFFFF_FFFF, 3'b000, 32'h4F80_0000, 1'b1, 2, 0);
        run("max_rtz",   32'hFFFF_FFFF, 3'b001, 32'h4F7F_FFFF, 1'b1, 2, 0);
        run("max_rm7",   32'hFFFF_FFFF, 3'b111, 32'h4F80_0000, 1'b1, 2, 0);
        run("bp_first",  32'h1234_5678, 3'b000, 32'h4D91_A2B4, 1'b1, 5, 10);
        run("bp_second", 32'h0000_0007, 3'b000, 32'h40E0_0000, 1'b0, 31, 0);

        // Abandon an operand mid-normalisation.
        @(negedge clk);
        in_valid = 1'b1;
        num1     = 32'h0000_0001;
        rm       = 3'b000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_num", out_num, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_stale", 32'(seen), 32'd0);
        run("after_rst", 32'h0000_0003, 3'b000, 32'h4040_0000, 1'b0, 32, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
